// File: rtl/router_fsm.sv
// Packet-level controller for the 1x3 router: header decode, payload load, full stall, parity load/check.
// Optional ROUTER_FSM_DROP_EN adds a DROP_PKT state that silently consumes packets addressed to 3.
module router_fsm #(
  parameter int NUM_DEST = 3,
  parameter int STATE_W  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_rst_0,
  input  logic       soft_rst_1,
  input  logic       soft_rst_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       write_enb_reg,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [STATE_W-1:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
`ifdef ROUTER_FSM_DROP_EN
    , DROP_PKT
`endif
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] addr_q;
  logic       addr_ok;
  logic       empty_in;
  logic       empty_q;
  logic       soft_hit;

  // Output bundle order: detect_add, write_enb_reg, lfd, ld, laf, full, rst_int_reg, busy
  function automatic logic [7:0] decode(input state_t s);
    case (s)
      DECODE_ADDRESS:     decode = 8'b1000_0000;
      LOAD_FIRST_DATA:    decode = 8'b0010_0001;
      LOAD_DATA:          decode = 8'b0101_0000;
      FIFO_FULL_STATE:    decode = 8'b0000_0101;
      LOAD_AFTER_FULL:    decode = 8'b0100_1001;
      LOAD_PARITY:        decode = 8'b0100_0001;
      CHECK_PARITY_ERROR: decode = 8'b0000_0011;
      WAIT_TILL_EMPTY:    decode = 8'b0000_0001;
      default:            decode = 8'b0000_0000;
    endcase
  endfunction

  assign addr_ok = (int'(data_in) < NUM_DEST);

  always_comb begin
    empty_in = 1'b0;
    case (data_in)
      2'd0:    empty_in = fifo_empty_0;
      2'd1:    empty_in = fifo_empty_1;
      2'd2:    empty_in = fifo_empty_2;
      default: empty_in = 1'b0;
    endcase
    empty_q  = 1'b0;
    soft_hit = 1'b0;
    case (addr_q)
      2'd0:    begin empty_q = fifo_empty_0; soft_hit = soft_rst_0; end
      2'd1:    begin empty_q = fifo_empty_1; soft_hit = soft_rst_1; end
      2'd2:    begin empty_q = fifo_empty_2; soft_hit = soft_rst_2; end
      default: begin empty_q = 1'b0;         soft_hit = 1'b0;       end
    endcase
  end

  always_comb begin
    nxt = state;
    if (soft_hit) begin
      nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid && addr_ok) nxt = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_DROP_EN
          else if (pkt_valid)       nxt = DROP_PKT;
`endif
        end
        LOAD_FIRST_DATA: nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) nxt = LOAD_PARITY;
        end
        FIFO_FULL_STATE: if (!fifo_full) nxt = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done)        nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) nxt = LOAD_PARITY;
          else                    nxt = LOAD_DATA;
        end
        LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:    if (empty_q) nxt = LOAD_FIRST_DATA;
`ifdef ROUTER_FSM_DROP_EN
        DROP_PKT:           if (!pkt_valid) nxt = DECODE_ADDRESS;
`endif
        default:            nxt = DECODE_ADDRESS;
      endcase
    end
  end

  // Outputs are registered from the next state, so they track the state register with no extra latency.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= DECODE_ADDRESS;
      addr_q <= '0;
      {detect_add, write_enb_reg, lfd_state, ld_state,
       laf_state, full_state, rst_int_reg, busy} <= decode(DECODE_ADDRESS);
    end else begin
      state <= nxt;
      if (state == DECODE_ADDRESS && pkt_valid) addr_q <= data_in;
      {detect_add, write_enb_reg, lfd_state, ld_state,
       laf_state, full_state, rst_int_reg, busy} <= decode(nxt);
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: per-scenario expected output traces built from the packet rules.
// Honours ROUTER_FSM_DROP_EN in the invalid-address scenario.
module tb_router_fsm;

  logic       clk;
  logic       rstn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] empty;
  logic [2:0] srst;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, write_enb_reg, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg, busy;
  logic [7:0] obs;

  int unsigned n_checks;
  int unsigned n_fail;
  logic        checking;

  // Expected output bundles {detect_add, write_enb_reg, lfd, ld, laf, full, rst_int_reg, busy}
  localparam logic [7:0] V_DEC  = 8'b1000_0000;
  localparam logic [7:0] V_LFD  = 8'b0010_0001;
  localparam logic [7:0] V_LD   = 8'b0101_0000;
  localparam logic [7:0] V_FULL = 8'b0000_0101;
  localparam logic [7:0] V_LAF  = 8'b0100_1001;
  localparam logic [7:0] V_LP   = 8'b0100_0001;
  localparam logic [7:0] V_CP   = 8'b0000_0011;
  localparam logic [7:0] V_WAIT = 8'b0000_0001;
  localparam logic [7:0] V_DROP = 8'b0000_0000;
  localparam logic [2:0] ALL    = 3'b111;
  localparam logic [2:0] NONE   = 3'b000;
  localparam logic       H      = 1'b1;
  localparam logic       L      = 1'b0;

  typedef struct {
    logic       rn;
    logic       pv;
    logic [1:0] d;
    logic       full;
    logic [2:0] emp;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
  } cyc_t;

  cyc_t tr[$];

  router_fsm #(.NUM_DEST(3), .STATE_W(4)) dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
    .fifo_empty_0(empty[0]), .fifo_empty_1(empty[1]), .fifo_empty_2(empty[2]),
    .soft_rst_0(srst[0]), .soft_rst_1(srst[1]), .soft_rst_2(srst[2]),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .write_enb_reg(write_enb_reg), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  assign obs = {detect_add, write_enb_reg, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase strobes must be mutually exclusive on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (checking) begin
      n_checks++;
      if ($countones(obs & 8'b1011_1110) > 1) begin
        n_fail++;
        $display("FAIL onehot t=%0t: strobes %b, required at most one set", $time, obs & 8'b1011_1110);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  function automatic logic [1:0] rd();
    return 2'($urandom_range(3));
  endfunction

  function automatic logic [2:0] oneh(input logic [1:0] a);
    return 3'(3'b001 << a);
  endfunction

  function automatic cyc_t mk(input logic rn, pv, input logic [1:0] d, input logic full,
                              input logic [2:0] emp, sr, input logic pd, lpv, input logic [7:0] exp);
    cyc_t c;
    c.rn = rn; c.pv = pv; c.d = d; c.full = full; c.emp = emp;
    c.sr = sr; c.pd = pd; c.lpv = lpv; c.exp = exp;
    return c;
  endfunction

  task automatic drive(input cyc_t c);
    rstn = c.rn; pkt_valid = c.pv; data_in = c.d; fifo_full = c.full;
    empty = c.emp; srst = c.sr; parity_done = c.pd; low_pkt_valid = c.lpv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tr.delete();
    tr.push_back(mk(L, rb(), rd(), rb(), 3'($urandom), 3'($urandom), rb(), rb(), V_DEC));
    tr.push_back(mk(L, rb(), rd(), rb(), 3'($urandom), 3'($urandom), rb(), rb(), V_DEC));
    tr.push_back(mk(H, H, 2'd1, L, ALL, NONE, L, L, V_LFD));
    tr.push_back(mk(H, H, rd(), L, ALL, NONE, L, L, V_LD));
    tr.push_back(mk(L, H, rd(), rb(), ALL, 3'($urandom), L, L, V_DEC));
    tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_DEC));
    foreach (tr[i]) begin
      drive(tr[i]);
      tick();
      checking = 1'b1;
      n_checks++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL reset step %0d: outputs %b, required %b", i, obs, tr[i].exp);
      end
    end
  endtask

  // Clean packet: n LD cycles, then parity; optionally the FIFO fills during the parity check.
  task automatic test_packet(input logic [1:0] a, input int unsigned n, input logic cp_full);
    int unsigned we_cnt, ri_cnt;
    we_cnt = 0; ri_cnt = 0;
    tr.delete();
    tr.push_back(mk(H, H, a, rb(), ALL, NONE, L, L, V_LFD));
    tr.push_back(mk(H, H, rd(), rb(), ALL, NONE, L, L, V_LD));
    for (int unsigned i = 1; i < n; i++) tr.push_back(mk(H, H, rd(), L, ALL, NONE, L, L, V_LD));
    tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_LP));
    tr.push_back(mk(H, L, rd(), rb(), ALL, NONE, L, L, V_CP));
    if (cp_full) begin
      tr.push_back(mk(H, L, rd(), H, ALL, NONE, L, L, V_FULL));
      tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_LAF));
      tr.push_back(mk(H, L, rd(), L, ALL, NONE, H, rb(), V_DEC));
    end else begin
      tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_DEC));
    end
    foreach (tr[i]) begin
      drive(tr[i]);
      tick();
      we_cnt += int'(write_enb_reg === 1'b1);
      ri_cnt += int'(rst_int_reg === 1'b1);
      n_checks++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL packet a=%0d n=%0d step %0d: outputs %b, required %b", a, n, i, obs, tr[i].exp);
      end
    end
    n_checks++;
    if (we_cnt != n + 1 + int'(cp_full)) begin
      n_fail++;
      $display("FAIL packet_wr_cycles a=%0d n=%0d: counted %0d, required %0d", a, n, we_cnt, n + 1 + int'(cp_full));
    end
    n_checks++;
    if (ri_cnt != 1) begin
      n_fail++;
      $display("FAIL packet_rst_int a=%0d: counted %0d, required 1", a, ri_cnt);
    end
  endtask

  // j clean LD cycles, then full held for m samples; br selects LAF exit: 0 LD, 1 parity, 2 done.
  task automatic test_full_stall(input logic [1:0] a, input int unsigned j, input int unsigned m,
                                 input int unsigned br);
    logic pv;
    pv = (br == 0);
    tr.delete();
    tr.push_back(mk(H, H, a, L, ALL, NONE, L, L, V_LFD));
    tr.push_back(mk(H, H, rd(), L, ALL, NONE, L, L, V_LD));
    for (int unsigned i = 0; i < j; i++) tr.push_back(mk(H, H, rd(), L, ALL, NONE, L, L, V_LD));
    for (int unsigned i = 0; i < m; i++) tr.push_back(mk(H, pv, rd(), H, ALL, NONE, L, L, V_FULL));
    tr.push_back(mk(H, pv, rd(), L, ALL, NONE, L, L, V_LAF));
    case (br)
      0: begin
        tr.push_back(mk(H, H, rd(), L, ALL, NONE, L, L, V_LD));
        tr.push_back(mk(H, H, rd(), L, ALL, NONE, L, L, V_LD));
        tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_LP));
        tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_CP));
        tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_DEC));
      end
      1: begin
        tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, H, V_LP));
        tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_CP));
        tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_DEC));
      end
      default: tr.push_back(mk(H, L, rd(), L, ALL, NONE, H, rb(), V_DEC));
    endcase
    foreach (tr[i]) begin
      drive(tr[i]);
      tick();
      n_checks++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL full_stall a=%0d j=%0d m=%0d br=%0d step %0d: outputs %b, required %b",
                 a, j, m, br, i, obs, tr[i].exp);
      end
    end
  endtask

  // Target FIFO busy for w cycles while the other FIFOs read empty and data_in wanders.
  task automatic test_wait(input logic [1:0] a, input int unsigned w);
    logic [2:0] others;
    others = ALL & ~oneh(a);
    tr.delete();
    tr.push_back(mk(H, H, a, rb(), others, NONE, L, L, V_WAIT));
    for (int unsigned i = 0; i < w; i++) tr.push_back(mk(H, rb(), rd(), rb(), others, NONE, rb(), rb(), V_WAIT));
    tr.push_back(mk(H, H, rd(), L, ALL, NONE, L, L, V_LFD));
    tr.push_back(mk(H, H, rd(), L, ALL, NONE, L, L, V_LD));
    tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_LP));
    tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_CP));
    tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_DEC));
    foreach (tr[i]) begin
      drive(tr[i]);
      tick();
      n_checks++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL wait_empty a=%0d w=%0d step %0d: outputs %b, required %b", a, w, i, obs, tr[i].exp);
      end
    end
  endtask

  // Soft reset of the addressed FIFO aborts LD, WAIT and FULL; other FIFOs' soft resets are ignored.
  task automatic test_soft_rst(input logic [1:0] a);
    logic [2:0] own, others;
    own = oneh(a);
    others = ALL & ~own;
    tr.delete();
    tr.push_back(mk(H, H, a, L, ALL, NONE, L, L, V_LFD));
    tr.push_back(mk(H, H, rd(), L, ALL, NONE, L, L, V_LD));
    tr.push_back(mk(H, H, rd(), L, ALL, others, L, L, V_LD));
    tr.push_back(mk(H, H, rd(), rb(), ALL, own, L, L, V_DEC));
    tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_DEC));
    tr.push_back(mk(H, H, a, L, others, NONE, L, L, V_WAIT));
    tr.push_back(mk(H, H, rd(), L, ALL, own, L, L, V_DEC));
    tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_DEC));
    tr.push_back(mk(H, H, a, L, ALL, NONE, L, L, V_LFD));
    tr.push_back(mk(H, H, rd(), L, ALL, NONE, L, L, V_LD));
    tr.push_back(mk(H, H, rd(), H, ALL, NONE, L, L, V_FULL));
    tr.push_back(mk(H, rb(), rd(), H, ALL, own, L, L, V_DEC));
    tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_DEC));
    foreach (tr[i]) begin
      drive(tr[i]);
      tick();
      n_checks++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL soft_rst a=%0d step %0d: outputs %b, required %b", a, i, obs, tr[i].exp);
      end
    end
  endtask

  task automatic test_invalid_addr();
    tr.delete();
`ifdef ROUTER_FSM_DROP_EN
    tr.push_back(mk(H, H, 2'd3, rb(), ALL, NONE, L, L, V_DROP));
    tr.push_back(mk(H, H, rd(), rb(), ALL, NONE, L, L, V_DROP));
    tr.push_back(mk(H, H, rd(), rb(), ALL, NONE, L, L, V_DROP));
    tr.push_back(mk(H, L, rd(), rb(), ALL, NONE, L, L, V_DEC));
`else
    for (int unsigned i = 0; i < 3; i++) tr.push_back(mk(H, H, 2'd3, rb(), ALL, NONE, L, L, V_DEC));
    tr.push_back(mk(H, L, 2'd3, rb(), ALL, NONE, L, L, V_DEC));
`endif
    tr.push_back(mk(H, L, rd(), L, ALL, NONE, L, L, V_DEC));
    foreach (tr[i]) begin
      drive(tr[i]);
      tick();
      n_checks++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL invalid_addr step %0d: outputs %b, required %b", i, obs, tr[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int unsigned k = 0; k < 4; k++) begin
      test_packet(2'($urandom_range(2)), $urandom_range(1, 6), rb());
      test_full_stall(2'($urandom_range(2)), $urandom_range(2), $urandom_range(1, 4), $urandom_range(2));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    checking = 1'b0;
    drive(mk(L, L, 2'd0, L, ALL, NONE, L, L, V_DEC));
    test_reset();
    test_packet(2'd1, 4, 1'b0);
    for (int unsigned k = 0; k < 3; k++) test_packet(2'($urandom_range(2)), $urandom_range(1, 6), rb());
    test_full_stall(2'd0, 1, 3, 0);
    for (int unsigned k = 0; k < 3; k++)
      test_full_stall(2'($urandom_range(2)), $urandom_range(2), $urandom_range(1, 4), $urandom_range(2));
    test_wait(2'd2, 3);
    test_wait(2'($urandom_range(2)), $urandom_range(0, 5));
    test_soft_rst(2'd0);
    test_soft_rst(2'($urandom_range(2)));
    test_invalid_addr();
    test_packet(2'($urandom_range(2)), $urandom_range(1, 6), 1'b0);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
